serial_subtractor: RTL

Bit-serial two's-complement subtractor. It computes DIFF = A - B - BIN one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the team's full-adder/ripple-adder cells. It serves datapaths where area matters more than latency, and uses a start/busy/done handshake.

---
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - BIN, LSB first, one full-subtractor step per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             d_bit;
    logic             br_next;
    logic             last;
    logic             load;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        last    = (cnt_q == CW'(WIDTH - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        load    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                load = start;
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = WIDTH'({d_bit, r_q} >> 1);
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    diff_d  = WIDTH'({d_bit, r_q} >> 1);
                    bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // br_q is the borrow into the MSB on this final step
                    ovf_d   = br_q ^ br_next;
`endif
                end
            end
            DONE: begin
                load    = start;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            br_d    = bin;
            r_d     = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
